// File: rtl/sr_latch_driver.sv
// sr_latch_driver
//   Initiator for a bank of WIDTH level-sensitive SR latches. Accepts a
//   one-word write request and derives per-bit Set/Reset strobes from the
//   difference between the requested word and the current latch Q. It drives
//   those strobes together with latch_en for PULSE_CYCLES cycles, then lets
//   the bank settle for one cycle and compares the readback. On a mismatch it
//   retries up to MAX_RETRY times. Completion is signalled by a one-cycle
//   done pulse, and err reports that the retries ran out.
//
// Ports
//   clk      in   system clock, rising edge
//   reset    in   asynchronous active-high reset
//   req      in   write request, sampled only while idle
//   wr_data  in   [WIDTH]  word to store, captured when req is accepted
//   q_in     in   [WIDTH]  latch bank Q readback
//   s_out    out  [WIDTH]  per-bit Set strobes
//   r_out    out  [WIDTH]  per-bit Reset strobes
//   latch_en out  latch transparency enable
//   busy     out  request in progress (PULSE/SETTLE/CHECK)
//   done     out  one-cycle completion pulse
//   err      out  retries exhausted; held until the next request is accepted
module sr_latch_driver #(
  parameter int WIDTH        = 32,
  parameter int PULSE_CYCLES = 2,
  parameter int MAX_RETRY    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] s_out,
  output logic [WIDTH-1:0] r_out,
  output logic             latch_en,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam int PW = (PULSE_CYCLES <= 1) ? 1 : $clog2(PULSE_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    PULSE,
    SETTLE,
    CHECK,
    FIN
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic [PW-1:0]    pcnt_q, pcnt_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             le_q, le_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  // Strobe masks against the live readback. While idle the target is the
  // incoming word, otherwise the captured one. Set and Reset are disjoint by
  // construction, and bits that already match are never strobed.
  logic [WIDTH-1:0] tgt;
  logic [WIDTH-1:0] s_new;
  logic [WIDTH-1:0] r_new;

  always_comb begin
    tgt   = (state_q == IDLE) ? wr_data : data_q;
    s_new = tgt & ~q_in;
    r_new = ~tgt & q_in;
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    retry_d = retry_q;
    pcnt_d  = pcnt_q;
    s_d     = '0;
    r_d     = '0;
    le_d    = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          data_d  = wr_data;
          retry_d = '0;
          pcnt_d  = '0;
          err_d   = 1'b0;
          if ((s_new | r_new) == '0) begin
            state_d = FIN;
            done_d  = 1'b1;
          end else begin
            state_d = PULSE;
            s_d     = s_new;
            r_d     = r_new;
            le_d    = 1'b1;
            busy_d  = 1'b1;
          end
        end
      end
      PULSE: begin
        busy_d = 1'b1;
        if (pcnt_q == PW'(PULSE_CYCLES - 1)) begin
          state_d = SETTLE;
        end else begin
          pcnt_d = pcnt_q + PW'(1);
          s_d    = s_q;
          r_d    = r_q;
          le_d   = 1'b1;
        end
      end
      SETTLE: begin
        busy_d  = 1'b1;
        state_d = CHECK;
      end
      CHECK: begin
        if (q_in == data_q) begin
          state_d = FIN;
          done_d  = 1'b1;
        end else if (retry_q != RW'(MAX_RETRY)) begin
          state_d = PULSE;
          retry_d = retry_q + RW'(1);
          pcnt_d  = '0;
          s_d     = s_new;
          r_d     = r_new;
          le_d    = 1'b1;
          busy_d  = 1'b1;
        end else begin
          state_d = FIN;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      retry_q <= '0;
      pcnt_q  <= '0;
      s_q     <= '0;
      r_q     <= '0;
      le_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      retry_q <= retry_d;
      pcnt_q  <= pcnt_d;
      s_q     <= s_d;
      r_q     <= r_d;
      le_q    <= le_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign s_out    = s_q;
  assign r_out    = r_q;
  assign latch_en = le_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_sr_latch_driver.sv
module tb_sr_latch_driver;

  localparam int W  = 8;
  localparam int P  = 2;
  localparam int MR = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         req;
  logic [W-1:0] wr_data;
  logic [W-1:0] q_in;
  logic [W-1:0] s_out, r_out;
  logic         latch_en, busy, done, err;

  int checks = 0;
  int errors = 0;

  // Latch bank model with fault injection.
  logic [W-1:0] bank;
  logic [W-1:0] stuck0;   // bits that can never be set
  int           trans_k;  // bit 3 ignores the first trans_k bursts
  int           burst;
  logic         le_prev;

  assign q_in = bank;

  sr_latch_driver #(
    .WIDTH(W),
    .PULSE_CYCLES(P),
    .MAX_RETRY(MR)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .wr_data(wr_data),
    .q_in(q_in),
    .s_out(s_out),
    .r_out(r_out),
    .latch_en(latch_en),
    .busy(busy),
    .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  // Transparent latch behaviour, evaluated mid-cycle while enabled.
  always @(negedge clk) begin
    logic [W-1:0] nq;
    if (latch_en) begin
      if (!le_prev) burst = burst + 1;
      nq = ((bank | s_out) & ~r_out) & ~stuck0;
      if (burst <= trans_k) nq[3] = bank[3];
      bank = nq;
    end
    le_prev = latch_en;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One write transaction. The expected outcome is computed up front from the
  // ideal-latch rules: each burst strobes only the differing bits, then the
  // result is compared; at most MR+1 bursts.
  task automatic run_txn(input logic [W-1:0] init, input logic [W-1:0] d,
                         input logic [W-1:0] stk, input int tk, input bit noise);
    logic [W-1:0] mq, old;
    int n, exp_done, le_cnt, done_cyc, cyc;
    logic exp_err, err_at_done;
    mq = init & ~stk;
    n  = 0;
    while (mq != d && n <= MR) begin
      old = mq;
      mq  = ((mq | (d & ~mq)) & ~(~d & mq)) & ~stk;
      if (n < tk) mq[3] = old[3];
      n++;
    end
    exp_err  = (mq != d);
    exp_done = 1 + n * (P + 2);

    @(negedge clk);
    bank    = init & ~stk;
    stuck0  = stk;
    trans_k = tk;
    burst   = 0;
    wr_data = d;
    req     = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    le_cnt   = 0;
    done_cyc = -1;
    err_at_done = 1'b0;
    for (cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (noise && cyc <= 3) begin
        req = (cyc < 3);
        wr_data = W'($urandom);
      end
      chk("s_and_r", 32'(s_out & r_out), 0);
      if (!latch_en) chk("strobe_idle", 32'(s_out | r_out), 0);
      if (latch_en) le_cnt++;
      if (cyc == 1) begin
        chk("err_clr", 32'(err), 0);
        if (n > 0) begin
          chk("s_first", 32'(s_out), 32'(d & ~(init & ~stk)));
          chk("r_first", 32'(r_out), 32'(~d & (init & ~stk)));
          chk("busy_first", 32'(busy), 1);
        end
      end
      if (done) begin
        done_cyc = cyc;
        err_at_done = err;
        chk("busy_at_done", 32'(busy), 0);
        break;
      end
    end
    chk("done_cycle", 32'(done_cyc), 32'(exp_done));
    chk("err", 32'(err_at_done), 32'(exp_err));
    chk("pulse_cycles", 32'(le_cnt), 32'(n * P));
    chk("final_q", 32'(bank), 32'(mq));
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 0);
    chk("err_hold", 32'(err), 32'(exp_err));
  endtask

  initial begin
    reset   = 1'b1;
    req     = 1'b0;
    wr_data = '0;
    bank    = '0;
    stuck0  = '0;
    trans_k = 0;
    burst   = 0;
    le_prev = 1'b0;
    #12;
    chk("rst_outs", 32'({s_out, r_out, latch_en, busy, done, err}), 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_quiet", 32'({latch_en, busy, done}), 0);
    end

    run_txn(8'h0F, 8'hF0, 8'h00, 0, 1'b0);  // basic, done at 5
    run_txn(8'hA5, 8'hA5, 8'h00, 0, 1'b0);  // no change, done at 1
    run_txn(8'h00, 8'h08, 8'h08, 0, 1'b0);  // stuck bit 3, err at 17
    run_txn(8'h00, 8'h08, 8'h00, 1, 1'b0);  // transient, done at 9
    run_txn(8'h0F, 8'hF0, 8'h00, 0, 1'b1);  // req noise while busy ignored

    // Reset in the middle of a pulse burst.
    @(negedge clk);
    bank = 8'h33; stuck0 = '0; trans_k = 0; burst = 0;
    wr_data = 8'hCC; req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    @(posedge clk);
    #3 reset = 1'b1;
    #1 chk("rst_mid_pulse", 32'({s_out, r_out, latch_en, busy, done, err}), 0);
    @(negedge clk);
    reset = 1'b0;
    run_txn(8'h5A, 8'hC3, 8'h00, 0, 1'b0);

    for (int t = 0; t < 25; t++) begin
      logic [W-1:0] a, b, s;
      a = W'($urandom);
      b = W'($urandom);
      s = ($urandom_range(0, 3) == 0) ? W'(1 << $urandom_range(0, W - 1)) : '0;
      run_txn(a, b, s, int'($urandom_range(0, 4)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/sr_latch_driver.md
Name: sr_latch_driver

Overview:
- Initiator side of the SR-latch storage interface.
- Takes a single-word write request, derives per-bit Set/Reset strobes from the difference between the requested word and the latch bank's current Q, and drives those strobes with the latch enable for a fixed pulse width.
- Reads back Q and retries on mismatch, then reports done or err.
- Sits between register-write control logic and a WIDTH-bit bank of level-sensitive SR latches in the register file.

Parameters:
- WIDTH, 32, data width; number of latches driven.
- PULSE_CYCLES, 2, cycles S/R/latch_en are held per attempt; legal range >= 1.
- MAX_RETRY, 3, extra attempts after the first on readback mismatch; legal range >= 0.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  1  write request; sampled only in IDLE.
- wr_data  input  WIDTH  word to store; captured on req acceptance.
- q_in  input  WIDTH  readback of latch bank Q outputs.
- s_out  output  WIDTH  per-bit Set strobes to the latch bank.
- r_out  output  WIDTH  per-bit Reset strobes to the latch bank.
- latch_en  output  1  latch transparency enable (latch clk input).
- busy  output  1  high while a request is in progress.
- done  output  1  one-cycle completion pulse.
- err  output  1  retries exhausted; valid with done.

Behaviour:
- Reset, asynchronous, effective immediately including mid-operation:
  - state=IDLE.
  - s_out, r_out, latch_en, busy, done, err all 0.
  - Captured data and retry count cleared.
- All outputs are registered.
- States: IDLE, PULSE, SETTLE, CHECK, FIN.
- IDLE, req=1 at an edge:
  - Capture d=wr_data.
  - Compute s_next = d & ~q_in and r_next = ~d & q_in.
  - If s_next|r_next == 0: go to FIN (no strobes).
  - Else: go to PULSE with s_out=s_next, r_out=r_next, latch_en=1, busy=1, and reset the pulse counter.
- IDLE, req=0: stay in IDLE.
- req in any state other than IDLE is ignored; it is not queued.
- PULSE:
  - Hold s_out/r_out/latch_en for exactly PULSE_CYCLES cycles.
  - Then go to SETTLE.
- SETTLE:
  - s_out=0, r_out=0, latch_en=0 for one cycle.
  - Then go to CHECK.
- CHECK, one cycle, compares q_in against the captured d:
  - Match: go to FIN with err=0.
  - Mismatch and retry_cnt < MAX_RETRY: increment retry_cnt, recompute masks from the current q_in, and go to PULSE (latch_en=1 next cycle).
  - Mismatch and retry_cnt == MAX_RETRY: go to FIN with err=1.
- FIN:
  - done=1 and busy=0 for one cycle; err holds its value.
  - Next edge returns to IDLE with done=0.
  - err stays asserted until the next request is accepted, then clears.
- Invariant: (s_out & r_out) == 0 on every cycle; this follows from the mask construction.
- Invariant: s_out and r_out are 0 whenever latch_en=0.
- Latency, no retry, request accepted at edge 0:
  - latch_en high cycles 1..P.
  - SETTLE at P+1, CHECK at P+2, done at P+3.
  - With P=2, done is at cycle 5.
- Latency, no-change request: done at cycle 1.
- Each retry adds P+2 cycles.
- retry_cnt width is $clog2(MAX_RETRY+1), minimum 1.
- The compare uses all WIDTH bits; bits already correct are never strobed.

Test Plan:
All scenarios use WIDTH=8, P=2, MAX_RETRY=3, with the bench modelling the bank as ideal SR latches on latch_en.
- Reset then idle: assert reset mid-cycle -> all outputs 0 immediately; no activity while req=0.
- Basic write: q=0x0F, req with wr_data=0xF0 -> s_out=0xF0, r_out=0x0F, latch_en high cycles 1-2, done=1 at cycle 5, err=0, q=0xF0.
- No-change write: q=0xA5, wr_data=0xA5 -> latch_en never high, done at cycle 1, err=0.
- Stuck bit: bench holds q[3]=0, wr_data=0x08 -> 4 pulse bursts each with s_out=0x08, done with err=1 at cycle 5+3*4=17; err stays high until the next req is accepted.
- Transient fault: bit 3 ignores the first pulse only -> one retry, done at cycle 9, err=0.
- Req while busy plus reset mid-PULSE: req toggled during PULSE is ignored; reset during PULSE clears latch_en/s_out/r_out at once; a new req after reset completes normally.
